// File: rtl/mips_defs.sv
// Shared MIPS multi-cycle definitions: opcodes, FSM state encoding and
// datapath select encodings used by the control unit.
package mips_defs;
  localparam int OP_WIDTH    = 6;
  localparam int ALUOP_WIDTH = 3;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_RS   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  // Address arithmetic for lw/sw and branch compares both use the adder paths.
  function automatic logic [ALUOP_WIDTH-1:0] alu_sel(input logic [OP_WIDTH-1:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: alu_sel = ALU_SUB;
      OP_AND, OP_ANDI:                 alu_sel = ALU_AND;
      OP_ORI:                          alu_sel = ALU_OR;
      OP_SLL:                          alu_sel = ALU_SLL;
      OP_SLT, OP_SLTI:                 alu_sel = ALU_SLT;
      default:                         alu_sel = ALU_ADD;
    endcase
  endfunction

  function automatic logic sext_sel(input logic [OP_WIDTH-1:0] op);
    case (op)
      OP_ADDIU, OP_SLTI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_BLTZ:         sext_sel = 1'b1;
      default:                         sext_sel = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mc_op_decode.sv
// Opcode classifier: splits the opcode space into the instruction classes
// that steer the multi-cycle FSM.
module mc_op_decode
  import mips_defs::*;
#(
  parameter int              OP_W    = OP_WIDTH,
  parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
  input  logic [OP_W-1:0] op,
  output logic            is_rtype,
  output logic            is_imm,
  output logic            is_ls,
  output logic            is_br,
  output logic            is_jmp,
  output logic            is_halt
);
  always_comb begin
    is_rtype = 1'b0;
    is_imm   = 1'b0;
    is_ls    = 1'b0;
    is_br    = 1'b0;
    is_jmp   = 1'b0;
    is_halt  = (op == HALT_OP);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT: is_rtype = 1'b1;
      OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI:     is_imm   = 1'b1;
      OP_SW, OP_LW:                           is_ls    = 1'b1;
      OP_BEQ, OP_BNE, OP_BLTZ:                is_br    = 1'b1;
      OP_J, OP_JR, OP_JAL:                    is_jmp   = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS sequencer: IF/ID/EXE/MEM/WB FSM with datapath controls
// decoded combinationally from the current state and the live opcode.
module multi_cycle_control
  import mips_defs::*;
#(
  parameter int              OP_W    = OP_WIDTH,
  parameter int              ALUOP_W = ALUOP_WIDTH,
  parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [OP_W-1:0]    Op,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               RegWre,
  output logic [1:0]         PCSrc,
  output logic               InstrDone,
  output logic [2:0]         State
);
  state_t state, state_nxt;
  logic   is_rtype, is_imm, is_ls, is_br, is_jmp, is_halt, is_unk, taken;

  mc_op_decode #(.OP_W(OP_W), .HALT_OP(HALT_OP)) u_dec (
    .op      (Op),
    .is_rtype(is_rtype),
    .is_imm  (is_imm),
    .is_ls   (is_ls),
    .is_br   (is_br),
    .is_jmp  (is_jmp),
    .is_halt (is_halt)
  );

  // Unrecognised opcodes retire from ID like a nop.
  assign is_unk = ~(is_rtype | is_imm | is_ls | is_br | is_jmp | is_halt);
  assign taken  = ((Op == OP_BEQ) & zero) | ((Op == OP_BNE) & ~zero) |
                  ((Op == OP_BLTZ) & sign);

  always_ff @(posedge clk or negedge Rst)
    if (!Rst) state <= S_IF;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:     state_nxt = S_ID;
      S_ID:     if (is_br)                state_nxt = S_EXE_BR;
                else if (is_ls)           state_nxt = S_EXE_LS;
                else if (is_rtype | is_imm) state_nxt = S_EXE_AL;
                else                      state_nxt = S_IF;
      S_EXE_AL: state_nxt = S_WB_AL;
      S_EXE_LS: state_nxt = S_MEM;
      S_MEM:    state_nxt = (Op == OP_LW) ? S_WB_LD : S_IF;
      default:  state_nxt = S_IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = '0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    RegDst    = RD_RA;
    WrRegDSrc = 1'b0;
    RegWre    = 1'b0;
    PCSrc     = PC_NEXT;
    case (state)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      S_ID: begin
        PCWre = is_jmp | is_unk;
        case (Op)
          OP_J:   PCSrc = PC_JMP;
          OP_JR:  PCSrc = PC_RS;
          OP_JAL: begin
            PCSrc  = PC_JMP;
            RegWre = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXE_AL, S_EXE_LS, S_EXE_BR: begin
        ALUSrcA = (Op == OP_SLL);
        ALUSrcB = is_imm | is_ls;
        ExtSel  = sext_sel(Op);
        ALUOp   = alu_sel(Op);
        if (state == S_EXE_BR) begin
          PCWre = 1'b1;
          PCSrc = taken ? PC_BR : PC_NEXT;
        end
      end
      S_MEM: begin
        mRD   = (Op == OP_LW);
        mWR   = (Op == OP_SW);
        PCWre = (Op == OP_SW);
      end
      S_WB_AL: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = is_rtype ? RD_RD : RD_RT;
        PCWre     = 1'b1;
      end
      S_WB_LD: begin
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
        RegDst    = RD_RT;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
      end
      default: ;
    endcase
  end

  assign InstrDone = PCWre;
  assign State     = state;
endmodule
